// File: rtl/fft_capture_ctrl.sv
// fft_capture_ctrl
//   Captures one FFT output frame into the output FIFO that feeds the USB path.
//   When armed, the controller runs these steps in order:
//     1. Hold the FIFO in reset for FLUSH_LEN cycles.
//     2. Discard SKIP_LEN valid samples while the FFT pipeline fills.
//     3. Write FRAME_LEN {re,im} words to the FIFO.
//     4. Wait for the host to acknowledge readout.
//
// Build option:
//   FFT_CAPTURE_AUTOREARM_EN  If defined, host_ack goes straight back to FLUSH
//                             so frames run back to back. If undefined, each
//                             frame needs its own start pulse.
//
// Ports:
//   i_clk, i_resetn           clock; asynchronous active-low reset
//   i_start                   arm request (honoured only in IDLE)
//   i_abort                   return to IDLE from any state (wins over start)
//   i_host_ack                host has drained the frame
//   i_fft_valid, i_fft_re/im  FFT output sample stream
//   i_buff_full               FIFO write-side full flag
//   o_buff_din, o_buff_wr_en  FIFO write port ({re,im}, one cycle after the sample)
//   o_buff_rst                FIFO reset (also asserted while i_resetn is low)
//   o_busy                    high in every state except IDLE
//   o_frame_done              pulses together with the final write slot of a frame
//   o_overflow                sticky: a sample was dropped because the FIFO was full
//   o_sample_cnt              samples accounted for in the current frame
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | waiting for start
// FLUSH     | FIFO held in reset for FLUSH_LEN cycles
// SKIP      | discarding SKIP_LEN valid samples (pipeline fill)
// CAPTURE   | writing FRAME_LEN samples
// WAIT_HOST | frame complete; waiting for host_ack
module fft_capture_ctrl #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 1024,
  parameter int SKIP_LEN  = 1033,
  parameter int FLUSH_LEN = 8
) (
  input  logic                             i_clk,
  input  logic                             i_resetn,
  input  logic                             i_start,
  input  logic                             i_abort,
  input  logic                             i_host_ack,
  input  logic                             i_fft_valid,
  input  logic [DATA_W-1:0]                i_fft_re,
  input  logic [DATA_W-1:0]                i_fft_im,
  input  logic                             i_buff_full,
  output logic [2*DATA_W-1:0]              o_buff_din,
  output logic                             o_buff_wr_en,
  output logic                             o_buff_rst,
  output logic                             o_busy,
  output logic                             o_frame_done,
  output logic                             o_overflow,
  output logic [$clog2(FRAME_LEN+1)-1:0]   o_sample_cnt
);

  localparam int CNT_W   = $clog2(FRAME_LEN+1);
  localparam int TMR_MAX = (SKIP_LEN > FLUSH_LEN) ? SKIP_LEN : FLUSH_LEN;
  localparam int TMR_W   = $clog2(TMR_MAX+1);

`ifdef FFT_CAPTURE_AUTOREARM_EN
  localparam bit AUTOREARM = 1'b1;
`else
  localparam bit AUTOREARM = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FLUSH     = 3'd1,
    S_SKIP      = 3'd2,
    S_CAPTURE   = 3'd3,
    S_WAIT_HOST = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [TMR_W-1:0]    r_tmr;
  logic [2*DATA_W-1:0] r_din;
  logic                r_wr_en;
  logic                r_frame_done;
  logic                r_overflow;
  logic [CNT_W-1:0]    r_sample_cnt;

  logic w_tmr_zero;
  logic w_arm;
  logic w_cap;
  logic w_last;

  assign w_tmr_zero = (r_tmr == '0);

  // Entry into FLUSH: either a fresh start or an auto re-arm after host_ack.
  assign w_arm = !i_abort &&
                 ((r_state == S_IDLE && i_start) ||
                  (AUTOREARM && r_state == S_WAIT_HOST && i_host_ack));

  // An abort in the same cycle cancels the sample, so it is neither written nor counted.
  assign w_cap  = (r_state == S_CAPTURE) && i_fft_valid && !i_abort;
  assign w_last = w_cap && (r_sample_cnt == CNT_W'(FRAME_LEN-1));

  // State register
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:      if (i_start) w_state_nxt = S_FLUSH;
        S_FLUSH:     if (w_tmr_zero) w_state_nxt = S_SKIP;
        S_SKIP:      if (i_fft_valid && w_tmr_zero) w_state_nxt = S_CAPTURE;
        S_CAPTURE:   if (w_last) w_state_nxt = S_WAIT_HOST;
        S_WAIT_HOST: if (i_host_ack) w_state_nxt = AUTOREARM ? S_FLUSH : S_IDLE;
        default:     w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    o_busy     = (r_state != S_IDLE);
    o_buff_rst = !i_resetn || (r_state == S_FLUSH);
  end

  // Shared down-counter: the flush length first, then the skip length.
  // It reloads with the skip count on the last flush cycle.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_tmr <= '0;
    end else if (w_arm) begin
      r_tmr <= TMR_W'(FLUSH_LEN-1);
    end else if (r_state == S_FLUSH) begin
      r_tmr <= w_tmr_zero ? TMR_W'(SKIP_LEN-1) : r_tmr - 1'b1;
    end else if (r_state == S_SKIP && i_fft_valid && !w_tmr_zero) begin
      r_tmr <= r_tmr - 1'b1;
    end
  end

  // Capture datapath
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_din        <= '0;
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_sample_cnt <= '0;
    end else begin
      r_wr_en      <= w_cap && !i_buff_full;
      r_frame_done <= w_last;
      if (w_cap) begin
        r_din        <= {i_fft_re, i_fft_im};
        // A sample dropped because the FIFO is full still counts,
        // so the frame stays aligned to FRAME_LEN.
        r_sample_cnt <= r_sample_cnt + 1'b1;
        if (i_buff_full) r_overflow <= 1'b1;
      end else if (w_arm) begin
        r_sample_cnt <= '0;
        r_overflow   <= 1'b0;
      end
    end
  end

  assign o_buff_din   = r_din;
  assign o_buff_wr_en = r_wr_en;
  assign o_frame_done = r_frame_done;
  assign o_overflow   = r_overflow;
  assign o_sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_fft_capture_ctrl.sv
`timescale 1ns/1ps
module tb_fft_capture_ctrl;
  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 1024;
  localparam int SKIP_LEN  = 1033;
  localparam int FLUSH_LEN = 8;
  localparam int CNT_W     = $clog2(FRAME_LEN+1);
  localparam int LAST_V    = SKIP_LEN + FRAME_LEN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                resetn, start, abort, host_ack, fft_valid, buff_full;
  logic [DATA_W-1:0]   fft_re, fft_im;
  logic [2*DATA_W-1:0] buff_din;
  logic                buff_wr_en, buff_rst, busy, frame_done, overflow;
  logic [CNT_W-1:0]    sample_cnt;

  fft_capture_ctrl #(
    .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .SKIP_LEN(SKIP_LEN), .FLUSH_LEN(FLUSH_LEN)
  ) dut (
    .i_clk(clk), .i_resetn(resetn), .i_start(start), .i_abort(abort),
    .i_host_ack(host_ack), .i_fft_valid(fft_valid), .i_fft_re(fft_re),
    .i_fft_im(fft_im), .i_buff_full(buff_full), .o_buff_din(buff_din),
    .o_buff_wr_en(buff_wr_en), .o_buff_rst(buff_rst), .o_busy(busy),
    .o_frame_done(frame_done), .o_overflow(overflow), .o_sample_cnt(sample_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state. A frame is described by how many cycles have
  // passed since it was armed and how many valid samples have arrived
  // after the flush window.
  bit                  m_armed;
  int                  m_cyc, m_vcnt, m_writes;
  logic [2*DATA_W-1:0] e_din;
  bit                  e_wr, e_done, e_ovf;
  int                  e_cnt;

  int n_wr, n_rst, n_edges, first_wr_edge;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_cyc = 0; m_vcnt = 0;
    e_din = '0; e_wr = 0; e_done = 0; e_ovf = 0; e_cnt = 0;
  endtask

  task automatic model_step();
    e_wr = 0; e_done = 0;
    if (!resetn) begin
      model_reset();
      return;
    end
    if (abort) begin
      m_armed = 0;
    end else if (!m_armed) begin
      if (start) begin
        m_armed = 1; m_cyc = 0; m_vcnt = 0; e_ovf = 0; e_cnt = 0;
      end
    end else begin
      if (m_cyc >= FLUSH_LEN && fft_valid && m_vcnt < LAST_V) begin
        m_vcnt++;
        if (m_vcnt > SKIP_LEN) begin
          e_din  = {fft_re, fft_im};
          e_wr   = !buff_full;
          e_ovf  = e_ovf | buff_full;
          e_cnt  = m_vcnt - SKIP_LEN;
          e_done = (m_vcnt == LAST_V);
          if (!buff_full) m_writes++;
        end
      end else if (m_vcnt == LAST_V && host_ack) begin
`ifdef FFT_CAPTURE_AUTOREARM_EN
        m_cyc = -1; m_vcnt = 0; e_ovf = 0; e_cnt = 0;
`else
        m_armed = 0;
`endif
      end
      if (m_cyc < 100000) m_cyc++;
    end
  endtask

  function automatic logic [63:0] obs_vec();
    return 64'({busy, buff_rst, buff_wr_en, frame_done, overflow, sample_cnt, buff_din});
  endfunction

  function automatic logic [63:0] exp_vec();
    logic rst_e;
    rst_e = !resetn || (m_armed && m_cyc < FLUSH_LEN);
    return 64'({m_armed, rst_e, e_wr, e_done, e_ovf, CNT_W'(e_cnt), e_din});
  endfunction

  task automatic clr_stats();
    n_wr = 0; n_rst = 0; n_edges = 0; first_wr_edge = -1; m_writes = 0;
  endtask

  task automatic tick(input bit s, input bit a, input bit h, input bit v, input bit f);
    start = s; abort = a; host_ack = h; fft_valid = v; buff_full = f;
    fft_re = DATA_W'($urandom);
    fft_im = DATA_W'($urandom);
    @(posedge clk);
    model_step();
    #1;
    n_edges++;
    if (buff_wr_en) begin
      n_wr++;
      if (first_wr_edge < 0) first_wr_edge = n_edges;
    end
    if (buff_rst) n_rst++;
    check("cycle", obs_vec(), exp_vec());
  endtask

  initial begin
    resetn = 0; start = 0; abort = 0; host_ack = 0; fft_valid = 0; buff_full = 0;
    fft_re = '0; fft_im = '0;
    model_reset();
    clr_stats();
    #1;
    check("reset_outputs", obs_vec(), 64'({1'b0, 1'b1, 3'b000, CNT_W'(0), 32'h0}));
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    resetn = 1;
    tick(0, 0, 0, 1, 0);
    check("idle_busy", 64'(busy), 64'(0));

    // T2 + T6: continuous valid, no backpressure.
    clr_stats();
    tick(1, 0, 0, 1, 0);
    for (int i = 0; i < 3000 && !frame_done; i++) tick(0, 0, 0, 1, 0);
    check("t2_done_seen", 64'(frame_done), 64'(1));
    check("t2_rst_cycles", 64'(n_rst), 64'(FLUSH_LEN));
    check("t2_first_write_edge", 64'(first_wr_edge), 64'(FLUSH_LEN + SKIP_LEN + 2));
    check("t2_writes", 64'(n_wr), 64'(FRAME_LEN));
    check("t2_cnt_at_done", 64'(sample_cnt), 64'(FRAME_LEN));
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 1, 0);
    check("t2_wait_no_writes", 64'(n_wr), 64'(FRAME_LEN));
    check("t2_busy_until_ack", 64'(busy), 64'(1));
`ifdef FFT_CAPTURE_AUTOREARM_EN
    clr_stats();
    tick(0, 0, 1, 1, 0);
    check("t6_busy_after_ack", 64'(busy), 64'(1));
    check("t6_flush_after_ack", 64'(buff_rst), 64'(1));
    for (int i = 0; i < 3000 && !frame_done; i++) tick(0, 0, 0, 1, 0);
    check("t6_done_seen", 64'(frame_done), 64'(1));
    check("t6_writes", 64'(n_wr), 64'(FRAME_LEN));
    check("t6_rst_cycles", 64'(n_rst), 64'(FLUSH_LEN));
    tick(0, 1, 0, 0, 0);
`else
    tick(0, 0, 1, 0, 0);
`endif
    check("t2_idle_after_end", 64'(busy), 64'(0));
    tick(0, 0, 1, 1, 0);
    check("ack_in_idle_ignored", 64'(busy), 64'(0));

    // T3: three full cycles mid-capture.
    clr_stats();
    tick(1, 0, 0, 1, 0);
    for (int i = 0; i < 3000 && !frame_done; i++)
      tick(0, 0, 0, 1, (e_cnt >= 100 && e_cnt < 103));
    check("t3_done_seen", 64'(frame_done), 64'(1));
    check("t3_writes", 64'(n_wr), 64'(FRAME_LEN - 3));
    check("t3_cnt_at_done", 64'(sample_cnt), 64'(FRAME_LEN));
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0);
    check("t3_overflow_sticky", 64'(overflow), 64'(1));
    tick(0, 1, 0, 0, 0);
    check("t3_overflow_after_abort", 64'(overflow), 64'(1));
    check("t3_abort_busy", 64'(busy), 64'(0));
    tick(1, 0, 0, 0, 0);
    check("t3_overflow_cleared_by_start", 64'(overflow), 64'(0));

    // T4: abort in SKIP, abort in CAPTURE, start+abort in IDLE.
    for (int i = 0; i < 20; i++) tick(0, 0, 0, 1, 0);
    tick(0, 1, 0, 1, 0);
    check("t4_abort_skip_busy", 64'(busy), 64'(0));
    clr_stats();
    for (int i = 0; i < 30; i++) tick(0, 0, 0, 1, 0);
    check("t4_no_writes_after_skip_abort", 64'(n_wr), 64'(0));
    tick(1, 0, 0, 1, 0);
    for (int i = 0; i < 1500 && e_cnt < 50; i++) tick(0, 0, 0, 1, 0);
    check("t4_reached_capture", 64'(sample_cnt), 64'(50));
    tick(0, 1, 0, 1, 0);
    check("t4_abort_suppresses_write", 64'(buff_wr_en), 64'(0));
    check("t4_abort_cap_busy", 64'(busy), 64'(0));
    clr_stats();
    for (int i = 0; i < 20; i++) tick(0, 0, 0, 1, 0);
    check("t4_no_writes_after_cap_abort", 64'(n_wr), 64'(0));
    tick(1, 1, 0, 1, 0);
    check("t4_start_abort_busy", 64'(busy), 64'(0));
    check("t4_start_abort_rst", 64'(buff_rst), 64'(0));

    // T5: random valid pattern, occasional full, stray start/ack pulses.
    clr_stats();
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 9000 && !frame_done; i++)
      tick(($urandom_range(63) == 0), 0, ($urandom_range(63) == 0),
           $urandom_range(1), ($urandom_range(15) == 0));
    check("t5_done_seen", 64'(frame_done), 64'(1));
    check("t5_writes", 64'(n_wr), 64'(m_writes));
    tick(0, 1, 0, 0, 0);

    // T1: asynchronous reset mid-capture.
    tick(1, 0, 0, 1, 0);
    for (int i = 0; i < 2000 && e_cnt < 500; i++) tick(0, 0, 0, 1, 0);
    check("t1_cnt_before_reset", 64'(sample_cnt), 64'(500));
    #2 resetn = 0;
    #1;
    model_reset();
    check("t1_async_outputs", obs_vec(), 64'({1'b0, 1'b1, 3'b000, CNT_W'(0), 32'h0}));
    tick(0, 0, 0, 1, 0);
    resetn = 1;
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 0);
    check("t1_idle_after_release", 64'(busy), 64'(0));
    tick(1, 0, 0, 0, 0);
    check("t1_restart_flush", 64'(buff_rst), 64'(1));
    tick(0, 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
